// File: rtl/core_mem_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the core memory arbiter.
package core_mem_pkg;

  typedef enum logic [1:0] {REQ_IF, REQ_DM, REQ_DBG} req_id_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} arb_state_t;

  localparam logic [2:0] FN3_LB  = 3'd0;
  localparam logic [2:0] FN3_LH  = 3'd1;
  localparam logic [2:0] FN3_LW  = 3'd2;
  localparam logic [2:0] FN3_LBU = 3'd4;
  localparam logic [2:0] FN3_LHU = 3'd5;
  localparam logic [2:0] FN3_SB  = 3'd0;
  localparam logic [2:0] FN3_SH  = 3'd1;
  localparam logic [2:0] FN3_SW  = 3'd2;

  // size is fn3[1:0]: 00 byte, 01 half, 10 word; 11 is caught as an illegal fn3
  function automatic logic is_misaligned(input logic word_only, input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    if (word_only) begin
      mis = (addr_lo != 2'b00);
    end else begin
      case (size)
        2'b00:   mis = 1'b0;
        2'b01:   mis = addr_lo[0];
        default: mis = (addr_lo != 2'b00);
      endcase
    end
    return mis;
  endfunction

  function automatic logic is_illegal_fn3(input logic we, input logic [2:0] fn3);
    logic bad;
    if (we) bad = (fn3 > 3'd2);
    else    bad = (fn3 == 3'd3) || (fn3 == 3'd6) || (fn3 == 3'd7);
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data replication/byte enables and
// load lane extraction with RV32 sign/zero extension.
module mem_lane_align
  import core_mem_pkg::*;
(
  input  logic [2:0]  st_fn3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_fn3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0]        ld_shift;
  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data;
    case (st_fn3)
      FN3_SB: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      FN3_SH: begin
        st_be    = 4'b0011 << st_addr_lo;
        st_wdata = {2{st_data[15:0]}};
      end
      FN3_SW: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  // Lane selected by the low address bits lands in bits [15:0] before extension
  always_comb begin
    ld_shift = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_byte  = $signed(ld_shift[7:0]);
    ld_half  = $signed(ld_shift[15:0]);
    case (ld_fn3)
      FN3_LB:  ld_data = 32'(ld_byte);
      FN3_LH:  ld_data = 32'(ld_half);
      FN3_LBU: ld_data = {24'h0, ld_shift[7:0]};
      FN3_LHU: ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Fixed-priority (DBG > DM > IF) arbiter sharing one single-port synchronous RAM,
// with a three-state access cycle and registered one-cycle responses.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter bit          DBG_EN      = 1'b1,
  localparam int         MEM_AW      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_req_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic              dm_req_we,
  input  logic [2:0]        dm_req_fn3,
  input  logic [31:0]       dm_req_addr,
  input  logic [31:0]       dm_req_wdata,
  output logic              dm_rsp_valid,
  output logic [31:0]       dm_rsp_data,
  output logic              dm_rsp_err,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [31:0]       dbg_req_addr,
  input  logic [31:0]       dbg_req_wdata,
  output logic              dbg_rsp_valid,
  output logic [31:0]       dbg_rsp_data,
  output logic              dbg_rsp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  arb_state_t  state_q, state_d;
  req_id_t     gnt;
  logic        req_any, req_we, req_word_only, req_err, in_range, accept;
  logic [2:0]  req_fn3;
  logic [31:0] req_addr, req_wdata, req_off;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  req_id_t     gnt_p1;
  logic        we_p1, err_p1;
  logic [2:0]  fn3_p1;
  logic [1:0]  lo_p1;

  logic        if_vld_p2, dm_vld_p2, dbg_vld_p2, rsp_err_p2;
  logic [31:0] rsp_data_p2;

  always_comb begin
    gnt           = REQ_IF;
    req_any       = 1'b0;
    req_we        = 1'b0;
    req_fn3       = FN3_LW;
    req_addr      = if_req_addr;
    req_wdata     = 32'h0;
    req_word_only = 1'b1;
    if (DBG_EN && dbg_req_valid) begin
      gnt       = REQ_DBG;
      req_any   = 1'b1;
      req_we    = dbg_req_we;
      req_addr  = dbg_req_addr;
      req_wdata = dbg_req_wdata;
    end else if (dm_req_valid) begin
      gnt           = REQ_DM;
      req_any       = 1'b1;
      req_we        = dm_req_we;
      req_fn3       = dm_req_fn3;
      req_addr      = dm_req_addr;
      req_wdata     = dm_req_wdata;
      req_word_only = 1'b0;
    end else if (if_req_valid) begin
      req_any = 1'b1;
    end
  end

  // Offset is compared in 33 bits so a RAM ending exactly at 2^32 still checks correctly
  always_comb begin
    req_off  = req_addr - ADDR_BASE;
    in_range = (req_addr >= ADDR_BASE) && ({1'b0, req_off} < SPAN);
    req_err  = !in_range
             || is_misaligned(req_word_only, req_fn3[1:0], req_addr[1:0])
             || (!req_word_only && is_illegal_fn3(req_we, req_fn3));
  end

  mem_lane_align u_align (
    .st_fn3     (req_fn3),
    .st_addr_lo (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_fn3     (fn3_p1),
    .ld_addr_lo (lo_p1),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data)
  );

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    if_req_ready  = 1'b0;
    dm_req_ready  = 1'b0;
    dbg_req_ready = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 4'b0000;
    mem_addr      = req_off[MEM_AW+1:2];
    mem_wdata     = st_wdata;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && req_any) begin
          accept        = 1'b1;
          if_req_ready  = (gnt == REQ_IF);
          dm_req_ready  = (gnt == REQ_DM);
          dbg_req_ready = (gnt == REQ_DBG);
          if (!req_err) begin
            mem_en = 1'b1;
            mem_we = req_we ? st_be : 4'b0000;
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // p1: request attributes captured at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_p1 <= REQ_IF;
      we_p1  <= 1'b0;
      fn3_p1 <= 3'd0;
      lo_p1  <= 2'b00;
      err_p1 <= 1'b0;
    end else if (accept) begin
      gnt_p1 <= gnt;
      we_p1  <= req_we;
      fn3_p1 <= req_fn3;
      lo_p1  <= req_addr[1:0];
      err_p1 <= req_err;
    end
  end

  // p2: response registered at the end of ACCESS, visible for the RESP cycle only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_vld_p2   <= 1'b0;
      dm_vld_p2   <= 1'b0;
      dbg_vld_p2  <= 1'b0;
      rsp_err_p2  <= 1'b0;
      rsp_data_p2 <= 32'h0;
    end else begin
      if_vld_p2  <= 1'b0;
      dm_vld_p2  <= 1'b0;
      dbg_vld_p2 <= 1'b0;
      if (state_q == ST_ACCESS) begin
        if_vld_p2   <= (gnt_p1 == REQ_IF);
        dm_vld_p2   <= (gnt_p1 == REQ_DM);
        dbg_vld_p2  <= (gnt_p1 == REQ_DBG);
        rsp_err_p2  <= err_p1;
        rsp_data_p2 <= (err_p1 || we_p1) ? 32'h0 : ld_data;
      end
    end
  end

  assign if_rsp_valid  = if_vld_p2;
  assign dm_rsp_valid  = dm_vld_p2;
  assign dbg_rsp_valid = dbg_vld_p2;
  assign if_rsp_data   = rsp_data_p2;
  assign dm_rsp_data   = rsp_data_p2;
  assign dbg_rsp_data  = rsp_data_p2;
  assign if_rsp_err    = rsp_err_p2;
  assign dm_rsp_err    = rsp_err_p2;
  assign dbg_rsp_err   = rsp_err_p2;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed-vector bench for core_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_core_mem_arbiter;

  localparam int AW = 12;

  logic          clk, rst_n;
  logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0]   if_req_addr, if_rsp_data;
  logic          dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid, dm_rsp_err;
  logic [2:0]    dm_req_fn3;
  logic [31:0]   dm_req_addr, dm_req_wdata, dm_rsp_data;
  logic          dbg_req_valid, dbg_req_ready, dbg_req_we, dbg_rsp_valid, dbg_rsp_err;
  logic [31:0]   dbg_req_addr, dbg_req_wdata, dbg_rsp_data;
  logic          mem_en, busy;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] ram [4096];
  int n_run, n_fail;

  core_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
    .dm_req_fn3(dm_req_fn3), .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_err(dm_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", n_run, n_fail);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one DM request from just after a posedge in IDLE, ends just after the RESP posedge
  task automatic dm_txn(input string tag, input logic we, input logic [2:0] fn3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_en, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_data, input logic exp_err);
    dm_req_valid = 1'b1;
    dm_req_we    = we;
    dm_req_fn3   = fn3;
    dm_req_addr  = addr;
    dm_req_wdata = wdata;
    @(negedge clk);
    chk({tag, ".ready"}, dm_req_ready, 1'b1);
    chk({tag, ".mem_en"}, mem_en, exp_en);
    if (exp_en && we) begin
      chk({tag, ".mem_we"}, mem_we, exp_be);
      chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    end
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".c1_valid"}, dm_rsp_valid, 1'b0);
    chk({tag, ".c1_mem_en"}, mem_en, 1'b0);
    @(negedge clk);
    chk({tag, ".c2_valid"}, dm_rsp_valid, 1'b1);
    chk({tag, ".c2_data"}, dm_rsp_data, exp_data);
    chk({tag, ".c2_err"}, dm_rsp_err, exp_err);
    @(posedge clk); #1;
  endtask

  int dbg_rdy, dm_rdy, if_rdy, dbg_rsp, dm_rsp, if_rsp;
  logic [31:0] dbg_d, dm_d, if_d;
  logic seen;

  initial begin
    n_run = 0; n_fail = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    ram[4] = 32'h0050_0093; ram[8] = 32'h1122_3344; ram[12] = 32'hCAFE_F00D;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    if_req_valid = 0; if_req_addr = 0;
    dm_req_valid = 0; dm_req_we = 0; dm_req_fn3 = 0; dm_req_addr = 0; dm_req_wdata = 0;
    dbg_req_valid = 0; dbg_req_we = 0; dbg_req_addr = 0; dbg_req_wdata = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.if_valid", if_rsp_valid, 1'b0);
    chk("rst.dm_valid", dm_rsp_valid, 1'b0);
    chk("rst.dbg_valid", dbg_rsp_valid, 1'b0);
    chk("rst.dm_data", dm_rsp_data, 32'h0);
    chk("rst.dm_err", dm_rsp_err, 1'b0);
    chk("rst.mem_en", mem_en, 1'b0);
    chk("rst.mem_we", mem_we, 4'b0000);
    chk("rst.busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IF fetch of word 4
    if_req_valid = 1'b1; if_req_addr = 32'h8000_0010;
    @(negedge clk);
    chk("if.ready", if_req_ready, 1'b1);
    chk("if.mem_en", mem_en, 1'b1);
    chk("if.mem_addr", 32'(mem_addr), 32'd4);
    chk("if.mem_we", mem_we, 4'b0000);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("if.c1_valid", if_rsp_valid, 1'b0);
    chk("if.busy", busy, 1'b1);
    @(negedge clk);
    chk("if.c2_valid", if_rsp_valid, 1'b1);
    chk("if.c2_data", if_rsp_data, 32'h0050_0093);
    chk("if.c2_err", if_rsp_err, 1'b0);
    @(posedge clk); #1;

    // All three ports request together
    dbg_rdy = -1; dm_rdy = -1; if_rdy = -1; dbg_rsp = -1; dm_rsp = -1; if_rsp = -1;
    dbg_d = 0; dm_d = 0; if_d = 0;
    dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 32'h8000_0010;
    dm_req_valid = 1; dm_req_we = 0; dm_req_fn3 = 3'd2; dm_req_addr = 32'h8000_0020;
    if_req_valid = 1; if_req_addr = 32'h8000_0030;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dbg_req_ready && dbg_rdy < 0) dbg_rdy = c;
      if (dm_req_ready && dm_rdy < 0) dm_rdy = c;
      if (if_req_ready && if_rdy < 0) if_rdy = c;
      if (dbg_rsp_valid) begin dbg_rsp = c; dbg_d = dbg_rsp_data; end
      if (dm_rsp_valid) begin dm_rsp = c; dm_d = dm_rsp_data; end
      if (if_rsp_valid) begin if_rsp = c; if_d = if_rsp_data; end
      @(posedge clk); #1;
      if (dbg_rdy == c) dbg_req_valid = 0;
      if (dm_rdy == c) dm_req_valid = 0;
      if (if_rdy == c) if_req_valid = 0;
    end
    chk("prio.dbg_ready_cyc", dbg_rdy, 0);
    chk("prio.dm_ready_cyc", dm_rdy, 3);
    chk("prio.if_ready_cyc", if_rdy, 6);
    chk("prio.dbg_rsp_cyc", dbg_rsp, 2);
    chk("prio.dm_rsp_cyc", dm_rsp, 5);
    chk("prio.if_rsp_cyc", if_rsp, 8);
    chk("prio.dbg_data", dbg_d, 32'h0050_0093);
    chk("prio.dm_data", dm_d, 32'h1122_3344);
    chk("prio.if_data", if_d, 32'hCAFE_F00D);

    // Byte and halfword lanes
    dm_txn("sb", 1, 3'd0, 32'h8000_0003, 32'h0000_00A5, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0);
    dm_txn("lb", 0, 3'd0, 32'h8000_0003, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFF_FFA5, 0);
    dm_txn("lbu", 0, 3'd4, 32'h8000_0003, 32'h0, 1, 4'b0000, 32'h0, 32'h0000_00A5, 0);
    dm_txn("sh", 1, 3'd1, 32'h8000_0002, 32'h0000_8001, 1, 4'b1100, 32'h8001_8001, 32'h0, 0);
    dm_txn("lh", 0, 3'd1, 32'h8000_0002, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFF_8001, 0);
    dm_txn("lhu", 0, 3'd5, 32'h8000_0002, 32'h0, 1, 4'b0000, 32'h0, 32'h0000_8001, 0);
    dm_txn("lw0", 0, 3'd2, 32'h8000_0000, 32'h0, 1, 4'b0000, 32'h0, 32'h8001_0000, 0);
    dm_txn("sw", 1, 3'd2, 32'h8000_0008, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sw.ram2", ram[2], 32'hDEAD_BEEF);

    // Error cases: no RAM access, err=1, data=0
    dm_txn("lw_mis", 0, 3'd2, 32'h8000_0002, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
    dm_txn("lh_mis", 0, 3'd1, 32'h8000_0001, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
    dm_txn("ld_fn3_3", 0, 3'd3, 32'h8000_0000, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
    dm_txn("st_fn3_4", 1, 3'd4, 32'h8000_0000, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
    dm_txn("lo_range", 0, 3'd2, 32'h7FFF_FFFC, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
    dm_txn("hi_range", 0, 3'd2, 32'h8000_4000, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
    dm_txn("lw_last", 0, 3'd2, 32'h8000_3FFC, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 0);
    chk("err.ram0", ram[0], 32'h8001_0000);

    // Reset asserted while the DM load is in ACCESS
    dm_req_valid = 1; dm_req_we = 0; dm_req_fn3 = 3'd2; dm_req_addr = 32'h8000_0010;
    @(negedge clk);
    chk("mid.ready", dm_req_ready, 1'b1);
    @(posedge clk); #1;
    dm_req_valid = 0;
    chk("mid.busy_pre", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.dm_valid", dm_rsp_valid, 1'b0);
    chk("mid.mem_en", mem_en, 1'b0);
    chk("mid.busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen = seen | dm_rsp_valid | if_rsp_valid | dbg_rsp_valid;
    end
    chk("mid.no_late_rsp", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
